// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - recovers pixel position from VGA syncs and checks their timing
// Ports:
//   clk          system clock, all state changes on its rising edge
//   reset        synchronous active-low reset
//   pix_en       sample strobe; syncs are only looked at when it is 1
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
//   x, y         recovered column/line, forced to 0 while not locked
//   display_area recovered position is visible and the block is locked
//   frame_start  one-sample pulse at recovered (0,0) while locked
//   locked       timing has matched the parameters for two full frames
//   err_cnt      saturating count of timing violations
//   h_period     last measured line length in samples
module vga_sync_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        display_area,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [11:0] h_period
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LOAD   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LOAD   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [11:0] H_TOT_W  = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_TOT_W  = 12'(V_TOTAL);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        acq_q, acq_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [11:0] per_cnt_q, per_cnt_d;
  logic        per_valid_q, per_valid_d;
  logic [11:0] h_period_q, h_period_d;
  logic [11:0] width_q, width_d;
  logic [11:0] line_q, line_d;
  logic        line_valid_q, line_valid_d;
  logic        armed_q, armed_d;
  logic [7:0]  err_q, err_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        disp_q, disp_d;
  logic        fs_q, fs_d;

  logic h_fall, h_rise, v_fall, h_wrap;
  logic per_bad, width_bad, line_bad, viol;
  logic lock_d;

  // Edge detection, position counters and timing measurements
  always_comb begin
    h_fall = pix_en & hs_q & ~h_sync;
    h_rise = pix_en & ~hs_q & h_sync;
    v_fall = pix_en & vs_q & ~v_sync;
    h_wrap = 1'b0;

    hs_d         = hs_q;
    vs_d         = vs_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    per_cnt_d    = per_cnt_q;
    per_valid_d  = per_valid_q;
    h_period_d   = h_period_q;
    width_d      = width_q;
    line_d       = line_q;
    line_valid_d = line_valid_q;
    armed_d      = armed_q;

    if (pix_en) begin
      hs_d = h_sync;
      vs_d = v_sync;

      // A sync reload takes priority over the wrap, so v only advances on a true wrap
      h_wrap = !h_fall && (h_cnt_q == H_LAST);
      if (h_fall)      h_cnt_d = H_LOAD;
      else if (h_wrap) h_cnt_d = '0;
      else             h_cnt_d = h_cnt_q + 10'd1;

      if (v_fall)      v_cnt_d = V_LOAD;
      else if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;

      // The first falling edge only starts the measurement; later ones report it
      if (h_fall) begin
        per_cnt_d   = 12'd1;
        per_valid_d = 1'b1;
        if (per_valid_q) h_period_d = per_cnt_q;
      end else if (per_cnt_q != CNT_MAX) begin
        per_cnt_d = per_cnt_q + 12'd1;
      end

      if (h_sync)                  width_d = '0;
      else if (width_q != CNT_MAX) width_d = width_q + 12'd1;

      if (v_fall) begin
        line_d       = {11'd0, h_fall};
        line_valid_d = 1'b1;
        armed_d      = 1'b1;
      end else if (h_fall && (line_q != CNT_MAX)) begin
        line_d = line_q + 12'd1;
      end
    end

    // Saturated counters are always wrong even if a parameter equals the max value
    per_bad   = h_fall && per_valid_q && ((per_cnt_q != H_TOT_W) || (per_cnt_q == CNT_MAX));
    width_bad = h_rise && ((width_q != H_SYNC_W) || (width_q == CNT_MAX));
    line_bad  = v_fall && line_valid_q && (line_q != V_TOT_W);
    viol      = per_bad | width_bad | line_bad;

    err_d = err_q;
    if (viol && armed_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // Lock FSM: a violation always wins over a coincident v_sync edge
  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    if (viol) begin
      state_d = SEARCH;
      acq_d   = 1'b0;
    end else if (v_fall) begin
      case (state_q)
        SEARCH: begin
          state_d = ACQUIRE;
          acq_d   = 1'b0;
        end
        ACQUIRE: begin
          if (acq_q) state_d = LOCKED;
          else       acq_d   = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Registered position outputs, aligned with the state they are qualified by
  always_comb begin
    lock_d = (state_d == LOCKED);
    x_d    = x_q;
    y_d    = y_q;
    disp_d = disp_q;
    fs_d   = 1'b0;
    if (pix_en) begin
      x_d    = lock_d ? h_cnt_d : '0;
      y_d    = lock_d ? v_cnt_d : '0;
      disp_d = lock_d && (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      fs_d   = lock_d && (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEARCH;
      acq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q   <= acq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      per_cnt_q    <= '0;
      per_valid_q  <= 1'b0;
      h_period_q   <= '0;
      width_q      <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      err_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      disp_q       <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      per_cnt_q    <= per_cnt_d;
      per_valid_q  <= per_valid_d;
      h_period_q   <= h_period_d;
      width_q      <= width_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      armed_q      <= armed_d;
      err_q        <= err_d;
      x_q          <= x_d;
      y_q          <= y_d;
      disp_q       <= disp_d;
      fs_q         <= fs_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign display_area = disp_q;
  assign frame_start  = fs_q;
  assign locked       = (state_q == LOCKED);
  assign err_cnt      = err_q;
  assign h_period     = h_period_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - self-checking bench for vga_sync_monitor on a reduced raster
module tb_vga_sync_monitor;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6, HT = 32;
  localparam int VA = 8, VFP = 2, VS = 2, VBP = 3, VT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [9:0]  x, y;
  logic        display_area, frame_start, locked;
  logic [7:0]  err_cnt;
  logic [11:0] h_period;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
    .x(x), .y(y), .display_area(display_area), .frame_start(frame_start),
    .locked(locked), .err_cnt(err_cnt), .h_period(h_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       disp;
    logic       fs;
  } exp_t;

  typedef struct {
    int len;
    int sw;
    int d_err;
    bit unlock;
  } rec_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   pe_div = 4;
  int   gx = 0, gy = 0;
  bit   sb_on = 1'b0;
  int   disp_cnt = 0, fs_cnt = 0;
  int   exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_disp"}, display_area, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_hperiod"}, h_period, 0);
  endtask

  task automatic do_sample(input logic hs, input logic vs);
    exp_t e;
    logic [9:0] x_prev;
    x_prev = x;
    for (int i = 1; i < pe_div; i++) begin
      pix_en = 1'b0;
      @(posedge clk); #1;
      if (sb_on) begin
        check("gap_fs_zero", frame_start, 0);
        check("gap_x_hold", x, x_prev);
      end
    end
    pix_en = 1'b1;
    h_sync = hs;
    v_sync = vs;
    if (sb_on) begin
      e.x    = 10'(gx);
      e.y    = 10'(gy);
      e.disp = (gx < HA) && (gy < VA);
      e.fs   = (gx == 0) && (gy == 0);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    pix_en = 1'b0;
    if (sb_on && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_x", x, e.x);
      check("sb_y", y, e.y);
      check("sb_disp", display_area, e.disp);
      check("sb_fs", frame_start, e.fs);
      disp_cnt += int'(display_area);
      fs_cnt   += int'(frame_start);
    end
  endtask

  task automatic gen_sample(input int len, input int sw);
    logic hs, vs;
    hs = !((gx >= HA + HFP) && (gx < HA + HFP + sw));
    vs = !((gy >= VA + VFP) && (gy < VA + VFP + VS));
    do_sample(hs, vs);
    gx++;
    if (gx >= len) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  task automatic run_until(input int tx, input int ty);
    int n;
    n = 0;
    do begin
      gen_sample(HT, HS);
      n++;
    end while (!(gx == tx && gy == ty) && n < 20000);
    if (n >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until_timeout: got %0d samples expected below 20000", n);
    end
  endtask

  rec_t tbl[6];

  initial begin
    tbl[0] = '{33, 6, 1, 1'b1};
    tbl[1] = '{31, 6, 1, 1'b1};
    tbl[2] = '{32, 5, 1, 1'b1};
    tbl[3] = '{32, 7, 1, 1'b1};
    tbl[4] = '{33, 5, 2, 1'b1};
    tbl[5] = '{32, 6, 0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Nominal timing, pix_en every 4th clock
    pe_div = 4; gx = 0; gy = 0;
    run_until(1, 10);
    check("lock_vf1", locked, 0);
    run_until(1, 10);
    check("lock_vf2", locked, 0);
    run_until(0, 10);
    check("lock_before_vf3", locked, 0);
    run_until(1, 10);
    check("lock_vf3", locked, 1);
    run_until(0, 0);
    sb_on = 1'b1; disp_cnt = 0; fs_cnt = 0;
    run_until(0, 0);
    sb_on = 1'b0;
    check("frame_disp_count", disp_cnt, HA * VA);
    check("frame_fs_count", fs_cnt, 1);
    check("nominal_hperiod", h_period, HT);
    check("nominal_err", err_cnt, 0);
    check("nominal_locked", locked, 1);

    // One long line while locked: lock drops at the next h_sync falling edge
    for (int k = 0; k < HT + 1; k++) gen_sample(HT + 1, HS);
    run_until(20, 1);
    check("long_pre_edge_locked", locked, 1);
    check("long_pre_edge_err", err_cnt, exp_err);
    gen_sample(HT, HS);
    exp_err++;
    check("long_edge_locked", locked, 0);
    check("long_edge_err", err_cnt, exp_err);
    check("long_edge_hperiod", h_period, HT + 1);
    run_until(0, 0);
    run_until(0, 0);
    check("long_relock_f1", locked, 0);
    run_until(0, 0);
    check("long_relock_f2", locked, 1);
    check("long_err_after", err_cnt, exp_err);

    // Table of single-line perturbations applied at the start of a locked frame
    pe_div = 2;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < tbl[r].len; k++) gen_sample(tbl[r].len, tbl[r].sw);
      run_until(0, 0);
      exp_err += tbl[r].d_err;
      check($sformatf("tbl%0d_err", r), err_cnt, exp_err);
      check($sformatf("tbl%0d_locked", r), locked, !tbl[r].unlock);
      if (tbl[r].unlock) begin
        run_until(0, 0);
        check($sformatf("tbl%0d_relock_f1", r), locked, 0);
        run_until(0, 0);
        check($sformatf("tbl%0d_relock_f2", r), locked, 1);
      end
      check($sformatf("tbl%0d_hperiod", r), h_period, HT);
    end

    // h_sync held high long enough to saturate the period counter
    pe_div = 1;
    for (int k = 0; k < 5000; k++) do_sample(1'b1, 1'b1);
    check("hold_err", err_cnt, exp_err);
    check("hold_locked", locked, 1);
    gx = HA + HFP; gy = 0;
    gen_sample(HT, HS);
    exp_err++;
    check("sat_hperiod", h_period, 4095);
    check("sat_err", err_cnt, exp_err);
    check("sat_locked", locked, 0);
    run_until(0, 0);
    check("sat_err_after", err_cnt, exp_err);

    // Back-to-back narrow sync pulses, one violation per line
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < HT; k++) gen_sample(HT, HS - 1);
      exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
      check($sformatf("burst%0d_err", i), err_cnt, exp_err);
    end

    // Reset mid-line while locked, with pix_en low in the reset cycle
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_err = 0; gx = 0; gy = 0;
    run_until(0, 0);
    run_until(0, 0);
    run_until(0, 0);
    check("pre_reset_locked", locked, 1);
    run_until(5, 3);
    check("pre_reset_x", x, 4);
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b1;
    run_until(1, 10);
    check("post_reset_vf1", locked, 0);
    run_until(1, 10);
    check("post_reset_vf2", locked, 0);
    run_until(1, 10);
    check("post_reset_vf3", locked, 1);
    check("post_reset_err", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, h_sync low width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, v_sync low width in lines
- V_BP, 33, vertical back porch in lines
- H_TOTAL = sum of the four H values (800); V_TOTAL = sum of the four V values (525).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock; all logic on its rising edge
- reset, in, 1, synchronous, active-low reset
- pix_en, in, 1, pixel strobe; h_sync/v_sync are sampled only in cycles where it is 1
- h_sync, in, 1, horizontal sync, active low
- v_sync, in, 1, vertical sync, active low
- x, out, 10, recovered pixel column
- y, out, 10, recovered line
- display_area, out, 1, recovered position is visible and the block is locked
- frame_start, out, 1, one-cycle pulse at recovered position (0,0)
- locked, out, 1, timing matches the parameters
- err_cnt, out, 8, saturating count of timing violations
- h_period, out, 12, last measured line length in samples

Function
REQ-003 Cycles with pix_en=0 shall hold all state and outputs, except frame_start, which shall be 0 in any cycle that is not a counted sample.
REQ-004 Edge detection: sampled h_sync/v_sync are compared with the registers hs_q/vs_q, which update only on pix_en. A falling edge is q=1 and input=0.
REQ-005 h counter: an h_sync falling edge loads H_ACTIVE+H_FP (656). Otherwise it increments and wraps from H_TOTAL-1 to 0.
REQ-006 v counter: a v_sync falling edge loads V_ACTIVE+V_FP (490). Otherwise it increments when the h counter wraps to 0, and wraps from V_TOTAL-1 to 0.
REQ-007 x/y: registered copies of the h/v counters, updated the same cycle. Both are 0 while the block is not locked.
REQ-008 display_area = locked AND x<H_ACTIVE AND y<V_ACTIVE, registered with x/y.
REQ-009 frame_start is 1 for exactly one sample, in the sample where the h and v counters both become 0 while locked.
REQ-010 Line period counter (12 bit, saturates at 4095):
- set to 1 on an h_sync falling edge, otherwise +1 per sample;
- on each falling edge after the first, h_period latches the value before reload;
- nominal timing gives 800.
REQ-011 Sync width counter: counts consecutive low h_sync samples and is checked on the h_sync rising edge against H_SYNC.
REQ-012 Line counter: counts h_sync falling edges between v_sync falling edges and is checked on the v_sync falling edge against V_TOTAL.
REQ-013 Lock state machine has three states: SEARCH, ACQUIRE, LOCKED.
- SEARCH -> ACQUIRE on the first v_sync falling edge.
- ACQUIRE -> LOCKED after 2 consecutive v_sync falling edges with no violation in between.
- Any violation in ACQUIRE or LOCKED -> SEARCH.
- locked=1 only in LOCKED.
REQ-014 Violations:
- measured h_period != H_TOTAL;
- h_sync low width != H_SYNC;
- line count != V_TOTAL;
- period or width counter saturated.
REQ-015 Violation handling:
- each violation, in any state except SEARCH before its first v_sync edge, increments err_cnt by 1;
- err_cnt saturates at 255;
- simultaneous violations in one sample count once.
REQ-016 A v_sync falling edge that coincides with a violation is treated as violation first: the state goes to SEARCH and the edge re-arms the SEARCH -> ACQUIRE transition on the next v_sync falling edge.
REQ-017 Counters keep free-running while unlocked, so lock is regained without waiting for reset.

Reset
REQ-018 On clk with reset=0, the block shall set:
- x, y, display_area, frame_start, locked, err_cnt, h_period and all internal counters to 0;
- hs_q and vs_q to 1;
- the state to SEARCH.
REQ-019 Reset asserted mid-frame takes effect on the next clk edge regardless of pix_en. After release, behaviour is as from power-up.

Verification
REQ-020 Nominal 640x480 timing, pix_en every 4th clk, 3 frames:
- locked rises at the third v_sync falling edge;
- h_period=800 and err_cnt=0;
- frame_start pulses once per frame thereafter;
- display_area is high for 640x480 samples per frame.
REQ-021 Inject one 801-sample line while locked:
- err_cnt increments by 1;
- locked falls at that h_sync edge;
- relock occurs after 2 further clean frames.
REQ-022 h_sync pulse of 95 samples: err_cnt increments at the rising edge and the state goes to SEARCH.
REQ-023 Hold h_sync high for 5000 samples:
- the period counter saturates at 4095;
- exactly one violation is counted at the next falling edge.
REQ-024 Apply 300 back-to-back violations: err_cnt stops at 255.
REQ-025 Assert reset mid-line while locked: next cycle all outputs are 0, and the block is in SEARCH after release.
